// File: rtl/adc_sample_averager.sv
// rtl/adc_sample_averager.sv - paces ADC reads, averages 2^LOG2_AVG samples, valid/ready result output
module adc_sample_averager #(
  parameter int DATA_WIDTH = 16,
  parameter int LOG2_AVG   = 4,
  parameter int ROUND      = 1
) (
  input  logic                  clk_adc,
  input  logic                  rst,
  input  logic                  enable_i,
  input  logic                  clear_i,
  output logic                  sample_req_o,
  input  logic [DATA_WIDTH-1:0] sample_data_i,
  input  logic                  sample_valid_i,
  output logic [DATA_WIDTH-1:0] avg_data_o,
  output logic                  avg_valid_o,
  input  logic                  avg_ready_i,
  output logic [LOG2_AVG:0]     sample_count_o,
  output logic                  overrun_o
);

  localparam int ACC_W = DATA_WIDTH + LOG2_AVG;
  localparam int CNT_W = LOG2_AVG + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << LOG2_AVG) - 1);
  localparam logic [ACC_W:0]   RND      = (ROUND != 0) ? (ACC_W+1)'((1 << LOG2_AVG) / 2) : '0;

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                  state_q, state_d;
  logic [ACC_W-1:0]        acc_q, acc_d, acc_sum;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    last;
  logic                    load;
  logic                    drop;
  logic [ACC_W:0]          rounded;
  logic [DATA_WIDTH:0]     shifted;
  logic [DATA_WIDTH-1:0]   result;

  always_ff @(posedge clk_adc or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // A sample arriving with the enable fall is discarded along with the partial block.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    last    = 1'b0;
    acc_sum = acc_q + ACC_W'(sample_data_i);
    case (state_q)
      IDLE: begin
        acc_d = '0;
        cnt_d = '0;
        if (enable_i) state_d = ACCUM;
      end
      ACCUM: begin
        if (!enable_i) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end else if (sample_valid_i) begin
          if (cnt_q == LAST_CNT) begin
            last  = 1'b1;
            acc_d = '0;
            cnt_d = '0;
          end else begin
            acc_d = acc_sum;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Extra bit keeps the rounding carry; saturate if it reaches the result MSB.
  always_comb begin
    rounded = {1'b0, acc_sum} + RND;
    shifted = (DATA_WIDTH+1)'(rounded >> LOG2_AVG);
    result  = shifted[DATA_WIDTH] ? '1 : shifted[DATA_WIDTH-1:0];
    load    = last && (!avg_valid_o || avg_ready_i);
    drop    = last && avg_valid_o && !avg_ready_i;
  end

  always_ff @(posedge clk_adc or posedge rst) begin
    if (rst) begin
      avg_data_o  <= '0;
      avg_valid_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      if (load) begin
        avg_data_o  <= result;
        avg_valid_o <= 1'b1;
      end else if (avg_valid_o && avg_ready_i) begin
        avg_valid_o <= 1'b0;
      end
      if (drop)         overrun_o <= 1'b1;
      else if (clear_i) overrun_o <= 1'b0;
    end
  end

  assign sample_req_o   = (state_q == ACCUM);
  assign sample_count_o = cnt_q;

endmodule

// File: tb/tb_adc_sample_averager.sv
// tb/tb_adc_sample_averager.sv - table/scoreboard bench for adc_sample_averager across four parameter sets
module tb_adc_sample_averager;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_a, en_bcd, clear, valid, ready_a;
  logic        ready_bcd = 1'b1;
  logic [15:0] data;

  logic        req_a, avg_valid_a, ovr_a;
  logic [15:0] avg_a;
  logic [4:0]  cnt_a;
  logic        req_b, avg_valid_b, ovr_b;
  logic [15:0] avg_b;
  logic [2:0]  cnt_b;
  logic        req_c, avg_valid_c, ovr_c;
  logic [15:0] avg_c;
  logic [2:0]  cnt_c;
  logic        req_d, avg_valid_d, ovr_d;
  logic [15:0] avg_d;
  logic [0:0]  cnt_d;

  int checks = 0;
  int errors = 0;

  logic [15:0] qb[$];
  logic [15:0] qc[$];
  logic [15:0] qd[$];

  always #5 clk = ~clk;

  adc_sample_averager #(.DATA_WIDTH(16), .LOG2_AVG(4), .ROUND(0)) u_a (
    .clk_adc(clk), .rst(rst), .enable_i(en_a), .clear_i(clear), .sample_req_o(req_a),
    .sample_data_i(data), .sample_valid_i(valid), .avg_data_o(avg_a), .avg_valid_o(avg_valid_a),
    .avg_ready_i(ready_a), .sample_count_o(cnt_a), .overrun_o(ovr_a));

  adc_sample_averager #(.DATA_WIDTH(16), .LOG2_AVG(2), .ROUND(1)) u_b (
    .clk_adc(clk), .rst(rst), .enable_i(en_bcd), .clear_i(clear), .sample_req_o(req_b),
    .sample_data_i(data), .sample_valid_i(valid), .avg_data_o(avg_b), .avg_valid_o(avg_valid_b),
    .avg_ready_i(ready_bcd), .sample_count_o(cnt_b), .overrun_o(ovr_b));

  adc_sample_averager #(.DATA_WIDTH(16), .LOG2_AVG(2), .ROUND(0)) u_c (
    .clk_adc(clk), .rst(rst), .enable_i(en_bcd), .clear_i(clear), .sample_req_o(req_c),
    .sample_data_i(data), .sample_valid_i(valid), .avg_data_o(avg_c), .avg_valid_o(avg_valid_c),
    .avg_ready_i(ready_bcd), .sample_count_o(cnt_c), .overrun_o(ovr_c));

  adc_sample_averager #(.DATA_WIDTH(16), .LOG2_AVG(0), .ROUND(1)) u_d (
    .clk_adc(clk), .rst(rst), .enable_i(en_bcd), .clear_i(clear), .sample_req_o(req_d),
    .sample_data_i(data), .sample_valid_i(valid), .avg_data_o(avg_d), .avg_valid_o(avg_valid_d),
    .avg_ready_i(ready_bcd), .sample_count_o(cnt_d), .overrun_o(ovr_d));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [15:0] d);
    @(posedge clk); #1;
    data  = d;
    valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (avg_valid_b) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_round1: unexpected result %0h", avg_b);
      end else chk("sb_round1", avg_b, qb.pop_front());
    end
    if (avg_valid_c) begin
      if (qc.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_round0: unexpected result %0h", avg_c);
      end else chk("sb_round0", avg_c, qc.pop_front());
    end
    if (avg_valid_d) begin
      if (qd.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_passthru: unexpected result %0h", avg_d);
      end else chk("sb_passthru", avg_d, qd.pop_front());
    end
  end

  typedef struct {
    logic [15:0] s [4];
    logic [15:0] exp_r1;
    logic [15:0] exp_r0;
  } vec_t;

  vec_t tbl [7];

  initial begin
    tbl[0].s = '{16'h0001, 16'h0001, 16'h0001, 16'h0002}; tbl[0].exp_r1 = 16'h0001; tbl[0].exp_r0 = 16'h0001;
    tbl[1].s = '{16'h0001, 16'h0001, 16'h0002, 16'h0002}; tbl[1].exp_r1 = 16'h0002; tbl[1].exp_r0 = 16'h0001;
    tbl[2].s = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}; tbl[2].exp_r1 = 16'hFFFF; tbl[2].exp_r0 = 16'hFFFF;
    tbl[3].s = '{16'h0000, 16'h0000, 16'h0000, 16'h0000}; tbl[3].exp_r1 = 16'h0000; tbl[3].exp_r0 = 16'h0000;
    tbl[4].s = '{16'h8000, 16'h8001, 16'h0000, 16'h0001}; tbl[4].exp_r1 = 16'h4001; tbl[4].exp_r0 = 16'h4000;
    tbl[5].s = '{16'h0003, 16'h0000, 16'h0000, 16'h0000}; tbl[5].exp_r1 = 16'h0001; tbl[5].exp_r0 = 16'h0000;
    tbl[6].s = '{16'h0002, 16'h0000, 16'h0000, 16'h0000}; tbl[6].exp_r1 = 16'h0001; tbl[6].exp_r0 = 16'h0000;

    rst = 1'b1; en_a = 1'b0; en_bcd = 1'b0; clear = 1'b0;
    valid = 1'b0; data = '0; ready_a = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("rst_req", req_a, 0);
    chk("rst_valid", avg_valid_a, 0);
    chk("rst_data", avg_a, 0);
    chk("rst_count", cnt_a, 0);
    chk("rst_overrun", ovr_a, 0);
    rst = 1'b0;

    // Reset asserted mid-block with a held result
    en_a = 1'b1; ready_a = 1'b0;
    repeat (16) send(16'h0500);
    repeat (7) send(16'h0001);
    @(negedge clk);
    chk("mid_count", cnt_a, 7);
    chk("mid_valid", avg_valid_a, 1);
    chk("mid_data", avg_a, 16'h0500);
    rst = 1'b1;
    #1;
    chk("async_valid", avg_valid_a, 0);
    chk("async_data", avg_a, 0);
    chk("async_count", cnt_a, 0);
    chk("async_req", req_a, 0);
    chk("async_overrun", ovr_a, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rel_req", req_a, 1);
    chk("rel_count", cnt_a, 0);

    // Basic average
    ready_a = 1'b1;
    repeat (15) send(16'h1000);
    chk("basic_count15", cnt_a, 15);
    chk("basic_novalid", avg_valid_a, 0);
    send(16'h1000);
    @(negedge clk);
    chk("basic_valid", avg_valid_a, 1);
    chk("basic_data", avg_a, 16'h1000);
    chk("basic_count0", cnt_a, 0);
    @(negedge clk);
    chk("basic_pulse", avg_valid_a, 0);

    // Back-pressure drop case
    ready_a = 1'b0;
    repeat (16) send(16'h0100);
    @(negedge clk);
    chk("bp_first_valid", avg_valid_a, 1);
    chk("bp_first_ovr", ovr_a, 0);
    repeat (16) send(16'h0200);
    @(negedge clk);
    chk("bp_held_data", avg_a, 16'h0100);
    chk("bp_held_valid", avg_valid_a, 1);
    chk("bp_overrun", ovr_a, 1);
    @(posedge clk); #1; clear = 1'b1;
    @(posedge clk); #1; clear = 1'b0;
    chk("bp_clear", ovr_a, 0);
    chk("bp_still_valid", avg_valid_a, 1);

    // Accept in the exact completion cycle
    repeat (15) send(16'h0400);
    @(posedge clk); #1;
    data = 16'h0400; valid = 1'b1; ready_a = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0; ready_a = 1'b0;
    chk("acc_valid", avg_valid_a, 1);
    chk("acc_data", avg_a, 16'h0400);
    chk("acc_no_ovr", ovr_a, 0);
    ready_a = 1'b1;
    @(posedge clk); #1;
    chk("acc_drained", avg_valid_a, 0);

    // Abort partial block, including a sample on the enable fall
    repeat (5) send(16'h7777);
    chk("abort_count5", cnt_a, 5);
    @(posedge clk); #1;
    en_a = 1'b0; data = 16'h7777; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    chk("abort_req", req_a, 0);
    chk("abort_count", cnt_a, 0);
    repeat (3) @(posedge clk); #1;
    chk("abort_no_out", avg_valid_a, 0);
    en_a = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) send(16'(i * 16));
    @(negedge clk);
    chk("reen_valid", avg_valid_a, 1);
    chk("reen_data", avg_a, 16'h0078);
    en_a = 1'b0;

    // Table-driven rounding / saturation / pass-through
    en_bcd = 1'b1;
    @(posedge clk); #1;
    for (int v = 0; v < 7; v++) begin
      qb.push_back(tbl[v].exp_r1);
      qc.push_back(tbl[v].exp_r0);
      for (int j = 0; j < 4; j++) begin
        qd.push_back(tbl[v].s[j]);
        send(tbl[v].s[j]);
      end
    end
    repeat (3) @(posedge clk); #1;
    chk("sb_b_drained", qb.size(), 0);
    chk("sb_c_drained", qc.size(), 0);
    chk("sb_d_drained", qd.size(), 0);
    chk("passthru_count", cnt_d, 0);
    en_bcd = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
